// File: rtl/timer_irq_ctrl_if.sv
// Memory-mapped data bus between the MEM stage and the timer block.
// The master drives address, data and strobes; the slave returns
// combinational read data in the same cycle.
interface timer_irq_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output MemRead,
        output MemWrite,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  MemRead,
        input  MemWrite,
        output rdata
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Multi-channel timer / interrupt source.
// Each channel has a reload register (TH), an up-counter (TL) and a control
// register (TCON: en, irq_en, auto, pending). All channels advance on a
// shared prescaler tick. Pending bits are cleared through the W1C STATUS
// register. Reads are combinational so the pipeline can capture them in the
// same cycle as the access.
module timer_irq_ctrl #(
    parameter int          N_CH      = 2,
    parameter int          WIDTH     = 32,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_irq_ctrl_if.slave bus,
    output logic            IRQ,
    output logic [2:0]      irq_id
);

    localparam int              PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0]  PS_LAST  = PSW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Address decode results
    logic [31:0] off;
    logic [2:0]  ch_idx;
    logic [1:0]  reg_sel;
    logic        status_hit;
    logic        ch_valid;
    logic        wr_status;

    // Prescaler
    logic [PSW-1:0] presc_q;
    logic [PSW-1:0] presc_d;
    logic           tick;

    // Per-channel state exported for read-back and interrupt generation
    logic [N_CH-1:0][31:0] th_rd;
    logic [N_CH-1:0][31:0] tl_rd;
    logic [N_CH-1:0][31:0] tcon_rd;
    logic [N_CH-1:0]       pend_vec;
    logic [N_CH-1:0]       ie_vec;
    logic [N_CH-1:0]       active;
    logic [31:0]           rdata_c;

    // Decode the bus address into channel / register / STATUS selects
    always_comb begin
        off        = bus.addr - BASE_ADDR;
        ch_idx     = off[6:4];
        reg_sel    = off[3:2];
        status_hit = (off == 32'h0000_0100);
        // Offset 0xC inside a channel slot is a hole; misaligned never decodes
        ch_valid   = (off[31:7] == '0)
                  && ({29'd0, off[6:4]} < 32'(N_CH))
                  && (off[1:0] == 2'b00)
                  && (off[3:2] != 2'b11);
        wr_status  = bus.MemWrite && status_hit;
    end

    // Free-running prescaler; tick on its last count (always 1 when PRESCALE=1)
    always_comb begin
        tick    = (presc_q == PS_LAST);
        presc_d = tick ? '0 : presc_q + PSW'(1);
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] th_q, th_d;
            logic [WIDTH-1:0] tl_q, tl_d;
            logic             en_q, en_d;
            logic             ie_q, ie_d;
            logic             au_q, au_d;
            logic             pend_q, pend_d;
            logic             sel;
            logic             ovf;
            logic             cnt;

            // Count/reload first, then let bus writes override the result;
            // an overflow set of pending beats a same-cycle W1C clear
            always_comb begin
                sel    = ch_valid && (ch_idx == 3'(gi));
                ovf    = (tl_q == ALL_ONES);
                cnt    = tick && en_q;
                th_d   = th_q;
                tl_d   = tl_q;
                en_d   = en_q;
                ie_d   = ie_q;
                au_d   = au_q;
                pend_d = pend_q;
                if (cnt) begin
                    if (ovf) begin
                        tl_d = th_q;
                        if (!au_q) begin
                            en_d = 1'b0;
                        end
                    end else begin
                        tl_d = tl_q + WIDTH'(1);
                    end
                end
                if (wr_status && bus.wdata[gi]) begin
                    pend_d = 1'b0;
                end
                if (cnt && ovf && ie_q) begin
                    pend_d = 1'b1;
                end
                if (bus.MemWrite && sel) begin
                    case (reg_sel)
                        2'd0: th_d = bus.wdata[WIDTH-1:0];
                        2'd1: tl_d = bus.wdata[WIDTH-1:0];
                        2'd2: begin
                            en_d = bus.wdata[0];
                            ie_d = bus.wdata[1];
                            au_d = bus.wdata[2];
                        end
                        default: ;
                    endcase
                end
            end

            // Channel registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    th_q   <= '0;
                    tl_q   <= '0;
                    en_q   <= 1'b0;
                    ie_q   <= 1'b0;
                    au_q   <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    th_q   <= th_d;
                    tl_q   <= tl_d;
                    en_q   <= en_d;
                    ie_q   <= ie_d;
                    au_q   <= au_d;
                    pend_q <= pend_d;
                end
            end

            assign th_rd[gi]   = 32'(th_q);
            assign tl_rd[gi]   = 32'(tl_q);
            assign tcon_rd[gi] = {28'd0, pend_q, au_q, ie_q, en_q};
            assign pend_vec[gi] = pend_q;
            assign ie_vec[gi]   = ie_q;
        end
    endgenerate

    // Combinational read mux; anything not decoded reads as zero
    always_comb begin
        rdata_c = '0;
        if (status_hit) begin
            rdata_c[N_CH-1:0] = pend_vec;
        end else if (ch_valid) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_idx == 3'(c)) begin
                    case (reg_sel)
                        2'd0:    rdata_c = th_rd[c];
                        2'd1:    rdata_c = tl_rd[c];
                        2'd2:    rdata_c = tcon_rd[c];
                        default: rdata_c = '0;
                    endcase
                end
            end
        end
    end

    assign bus.rdata = rdata_c;

    // Interrupt line and lowest-numbered active channel
    always_comb begin
        active = pend_vec & ie_vec;
        IRQ    = |active;
        irq_id = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (active[c]) begin
                irq_id = 3'(c);
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: two instances (PRESCALE=1 and PRESCALE=4) share
// one stimulus stream and are compared every cycle against a behavioural
// model of the register map, plus directed scenarios with fixed expectations.
module tb_timer_irq_ctrl;

    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] ST   = BASE + 32'h100;

    logic       clk;
    logic       rst_n;
    logic       irq_p1, irq_p4;
    logic [2:0] id_p1, id_p4;

    timer_irq_ctrl_if bus_p1 ();
    timer_irq_ctrl_if bus_p4 ();

    timer_irq_ctrl #(.N_CH(N), .WIDTH(32), .PRESCALE(1), .BASE_ADDR(BASE)) u_dut_p1 (
        .clk(clk), .rst_n(rst_n), .bus(bus_p1), .IRQ(irq_p1), .irq_id(id_p1)
    );

    timer_irq_ctrl #(.N_CH(N), .WIDTH(32), .PRESCALE(4), .BASE_ADDR(BASE)) u_dut_p4 (
        .clk(clk), .rst_n(rst_n), .bus(bus_p4), .IRQ(irq_p4), .irq_id(id_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Behavioural model: index 0 = PRESCALE 1 instance, 1 = PRESCALE 4 instance
    logic [31:0] m_th [2][N];
    logic [31:0] m_tl [2][N];
    bit          m_en [2][N];
    bit          m_ie [2][N];
    bit          m_au [2][N];
    bit          m_pd [2][N];
    int          m_cyc[2];
    int          m_ps [2] = '{1, 4};

    logic [31:0] cur_a, cur_d;
    logic        cur_we;

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(int c, int r);
        return BASE + 32'(16 * c + 4 * r);
    endfunction

    function automatic logic [31:0] m_read(int i, logic [31:0] a);
        logic [31:0] o;
        logic [31:0] v;
        int          c;
        o = a - BASE;
        v = '0;
        if (a[1:0] == 2'b00) begin
            if (o == 32'h100) begin
                for (int k = 0; k < N; k++) v[k] = m_pd[i][k];
            end else if (o < 32'(16 * N)) begin
                c = int'(o) / 16;
                case (int'(o) % 16)
                    0:       v = m_th[i][c];
                    4:       v = m_tl[i][c];
                    8:       v = {28'd0, m_pd[i][c], m_au[i][c], m_ie[i][c], m_en[i][c]};
                    default: v = '0;
                endcase
            end
        end
        return v;
    endfunction

    function automatic bit m_irq(int i);
        for (int k = 0; k < N; k++) if (m_pd[i][k] && m_ie[i][k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] m_id(int i);
        for (int k = 0; k < N; k++) if (m_pd[i][k] && m_ie[i][k]) return 3'(k);
        return 3'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin
                m_th[i][k] = '0; m_tl[i][k] = '0;
                m_en[i][k] = 0;  m_ie[i][k] = 0;
                m_au[i][k] = 0;  m_pd[i][k] = 0;
            end
            m_cyc[i] = 0;
        end
    endtask

    // One clock edge of the model: tick every m_ps-th cycle since reset
    task automatic m_edge(int i);
        logic [31:0] o;
        int          wc, wr;
        bit          wst, tk, ovf, cnt, ne, np;
        logic [31:0] nt;
        tk  = (m_cyc[i] % m_ps[i]) == (m_ps[i] - 1);
        wc  = -1;
        wr  = -1;
        wst = 0;
        if (cur_we && cur_a[1:0] == 2'b00) begin
            o = cur_a - BASE;
            if (o == 32'h100) wst = 1;
            else if (o < 32'(16 * N) && o[3:2] != 2'b11) begin
                wc = int'(o) / 16;
                wr = int'(o[3:2]);
            end
        end
        for (int k = 0; k < N; k++) begin
            ovf = (m_tl[i][k] == 32'hFFFF_FFFF);
            cnt = tk && m_en[i][k];
            nt  = m_tl[i][k];
            ne  = m_en[i][k];
            np  = m_pd[i][k];
            if (cnt) begin
                if (ovf) begin
                    nt = m_th[i][k];
                    if (!m_au[i][k]) ne = 0;
                end else begin
                    nt = m_tl[i][k] + 32'd1;
                end
            end
            if (wst && cur_d[k]) np = 0;
            if (cnt && ovf && m_ie[i][k]) np = 1;
            m_tl[i][k] = nt;
            m_en[i][k] = ne;
            m_pd[i][k] = np;
            if (wc == k) begin
                case (wr)
                    0: m_th[i][k] = cur_d;
                    1: m_tl[i][k] = cur_d;
                    2: begin
                        m_en[i][k] = cur_d[0];
                        m_ie[i][k] = cur_d[1];
                        m_au[i][k] = cur_d[2];
                    end
                    default: ;
                endcase
            end
        end
        m_cyc[i]++;
    endtask

    task automatic set_bus(logic [31:0] a, logic [31:0] d, logic we);
        cur_a = a; cur_d = d; cur_we = we;
        bus_p1.addr = a; bus_p1.wdata = d; bus_p1.MemWrite = we; bus_p1.MemRead = !we;
        bus_p4.addr = a; bus_p4.wdata = d; bus_p4.MemWrite = we; bus_p4.MemRead = !we;
    endtask

    task automatic check_model();
        check_val("rdata_p1", bus_p1.rdata, m_read(0, cur_a));
        check_val("irq_p1", {31'd0, irq_p1}, {31'd0, m_irq(0)});
        check_val("irq_id_p1", {29'd0, id_p1}, {29'd0, m_id(0)});
        check_val("rdata_p4", bus_p4.rdata, m_read(1, cur_a));
        check_val("irq_p4", {31'd0, irq_p4}, {31'd0, m_irq(1)});
        check_val("irq_id_p4", {29'd0, id_p4}, {29'd0, m_id(1)});
    endtask

    task automatic clock_edge();
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        #1;
    endtask

    task automatic step(logic [31:0] a, logic [31:0] d, logic we);
        n_txn++;
        $display("txn %0d addr=%h wdata=%h we=%0d", n_txn, a, d, we);
        set_bus(a, d, we);
        #2;
        check_model();
        clock_edge();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(reg_addr(0, 1), 32'd0, 1'b0);
    endtask

    // Read with fixed expectations on one instance, plus the model check
    task automatic probe(int inst, string tag, logic [31:0] a, logic [31:0] exp_rd,
                         bit exp_irq, int exp_id);
        n_txn++;
        $display("txn %0d probe %s addr=%h", n_txn, tag, a);
        set_bus(a, 32'd0, 1'b0);
        #2;
        if (inst == 0) begin
            check_val({tag, "_rd"}, bus_p1.rdata, exp_rd);
            check_val({tag, "_irq"}, {31'd0, irq_p1}, {31'd0, exp_irq});
            check_val({tag, "_id"}, {29'd0, id_p1}, 32'(exp_id));
        end else begin
            check_val({tag, "_rd"}, bus_p4.rdata, exp_rd);
            check_val({tag, "_irq"}, {31'd0, irq_p4}, {31'd0, exp_irq});
            check_val({tag, "_id"}, {29'd0, id_p4}, 32'(exp_id));
        end
        check_model();
        clock_edge();
    endtask

    initial begin
        logic [31:0] a, d;
        logic        we;
        int          r, c, rg;

        // Reset state
        rst_n = 1'b0;
        m_reset();
        set_bus(reg_addr(0, 2), 32'd0, 1'b0);
        #12;
        check_val("rst_tcon", bus_p1.rdata, 32'd0);
        check_val("rst_irq", {31'd0, irq_p1}, 32'd0);
        check_val("rst_id", {29'd0, id_p4}, 32'd0);
        rst_n = 1'b1;
        clock_edge();

        // Auto-reload on ch0, then W1C colliding with an overflow
        step(reg_addr(0, 0), 32'hFFFF_FFFD, 1'b1);
        step(reg_addr(0, 1), 32'hFFFF_FFFD, 1'b1);
        step(reg_addr(0, 2), 32'h7, 1'b1);
        idle(3);
        probe(0, "t2_tl", reg_addr(0, 1), 32'hFFFF_FFFD, 1'b1, 0);
        probe(0, "t2_tcon", reg_addr(0, 2), 32'hF, 1'b1, 0);
        step(ST, 32'h1, 1'b1);
        probe(0, "t4_keep", ST, 32'h1, 1'b1, 0);
        step(ST, 32'h1, 1'b1);
        probe(0, "t4_clr", ST, 32'h0, 1'b0, 0);
        step(reg_addr(0, 2), 32'h0, 1'b1);
        step(ST, 32'hFF, 1'b1);

        // One-shot on ch1
        step(reg_addr(1, 0), 32'h0, 1'b1);
        step(reg_addr(1, 1), 32'hFFFF_FFFE, 1'b1);
        step(reg_addr(1, 2), 32'h3, 1'b1);
        idle(2);
        probe(0, "t3_tcon", reg_addr(1, 2), 32'hA, 1'b1, 1);
        probe(0, "t3_tl", reg_addr(1, 1), 32'h0, 1'b1, 1);
        idle(1);
        probe(0, "t3_hold", reg_addr(1, 1), 32'h0, 1'b1, 1);
        step(ST, 32'hFF, 1'b1);
        step(reg_addr(1, 2), 32'h0, 1'b1);

        // Bus write to TL beats a coinciding tick; unmapped read
        step(reg_addr(0, 1), 32'h20, 1'b1);
        step(reg_addr(0, 2), 32'h5, 1'b1);
        step(reg_addr(0, 1), 32'h10, 1'b1);
        probe(0, "t6_tl", reg_addr(0, 1), 32'h10, 1'b0, 0);
        probe(0, "t6_unmap", BASE + 32'hC, 32'h0, 1'b0, 0);
        step(reg_addr(0, 2), 32'h0, 1'b1);

        // Two channels pending with PRESCALE=4, masking, tick rate
        step(reg_addr(1, 2), 32'h0, 1'b1);
        step(ST, 32'hFF, 1'b1);
        step(reg_addr(0, 0), 32'h0, 1'b1);
        step(reg_addr(0, 1), 32'hFFFF_FFFF, 1'b1);
        step(reg_addr(1, 0), 32'h0, 1'b1);
        step(reg_addr(1, 1), 32'hFFFF_FFFF, 1'b1);
        step(reg_addr(0, 2), 32'h7, 1'b1);
        step(reg_addr(1, 2), 32'h7, 1'b1);
        idle(8);
        probe(1, "t5_both", ST, 32'h3, 1'b1, 0);
        step(reg_addr(0, 2), 32'h5, 1'b1);
        probe(1, "t5_mask", reg_addr(0, 2), 32'hD, 1'b1, 1);
        step(reg_addr(1, 1), 32'h100, 1'b1);
        idle(8);
        probe(1, "t5_rate", reg_addr(1, 1), 32'h102, 1'b1, 1);

        // Asynchronous reset in the middle of a count
        step(reg_addr(0, 0), 32'hFFFF_FFF0, 1'b1);
        step(reg_addr(0, 1), 32'hFFFF_FFF0, 1'b1);
        step(reg_addr(0, 2), 32'h7, 1'b1);
        idle(5);
        set_bus(reg_addr(0, 1), 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t1_tl_p1", bus_p1.rdata, 32'd0);
        check_val("t1_tl_p4", bus_p4.rdata, 32'd0);
        check_val("t1_irq_p1", {31'd0, irq_p1}, 32'd0);
        check_val("t1_irq_p4", {31'd0, irq_p4}, 32'd0);
        set_bus(reg_addr(0, 2), 32'd0, 1'b0);
        #1;
        check_val("t1_tcon_p1", bus_p1.rdata, 32'd0);
        check_val("t1_tcon_p4", bus_p4.rdata, 32'd0);
        m_reset();
        #1;
        rst_n = 1'b1;
        clock_edge();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            c  = $urandom_range(0, 3);
            rg = $urandom_range(0, 3);
            a  = reg_addr(c, rg);
            d  = $urandom;
            if ((rg == 0 || rg == 1) && $urandom_range(0, 1) == 1)
                d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (r == 0) a = ST;
            if (r == 1) a = a | 32'($urandom_range(1, 3));
            we = ($urandom_range(0, 1) == 1);
            step(a, d, we);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Parametrised, memory-mapped multi-channel timer and interrupt source on the MEM-stage data bus. It generalises the single TH/TL/TCON timer to N_CH independent channels. Each channel adds auto-reload and one-shot modes, a shared prescaler, and per-channel pending/mask. It drives the CPU IRQ line and an IRQ channel ID, and is read combinationally in the same cycle so that MEM_WB captures the read data.

Parameters:
N_CH, 2, number of timer channels (1..8)
WIDTH, 32, counter/reload width in bits (8..32)
PRESCALE, 1, tick period in clk cycles (>=1; 1 = tick every cycle)
BASE_ADDR, 32'h4000_0000, base of the register window

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address from EX_MEM_ALU_OUT
wdata  input  32  write data (EX_MEM_rt_data)
MemRead  input  1  bus read strobe
MemWrite  input  1  bus write strobe
rdata  output  32  combinational read data; 0 when no register is hit
IRQ  output  1  OR of (pending & irq_en) over channels
irq_id  output  3  lowest-numbered channel asserting IRQ; 0 when IRQ=0

Behaviour:
- Reset (async, rst_n=0): all TH, TL, TCON and pending = 0; prescaler = 0; IRQ=0, irq_id=0. Reset takes effect immediately, including mid-count or mid-write.
- Address map. Channel c occupies BASE_ADDR+16*c:
  - +0 TH: reload value
  - +4 TL: counter
  - +8 TCON
  - STATUS at BASE_ADDR+0x100
  - Only addr[1:0]=00 decodes; unmatched addresses are ignored on write and read as 0.
- TCON bits:
  - [0] en
  - [1] irq_en
  - [2] auto (1 = auto-reload, 0 = one-shot)
  - [3] pending (read-only mirror; writes to this bit are ignored)
  - [31:4] read 0
- STATUS: bits [N_CH-1:0] = pending. Writing 1 to a bit clears that bit (W1C); other bits read 0.
- TH and TL store wdata[WIDTH-1:0] and read zero-extended to 32 bits.
- Prescaler: free-running counter 0..PRESCALE-1, independent of the enables. tick=1 in the cycle the counter equals PRESCALE-1. With PRESCALE=1, tick is constant 1.
- Per channel, on a tick with en=1:
  - TL != all-ones: TL <= TL+1.
  - TL == all-ones (overflow): TL <= TH; pending <= 1 if irq_en; if auto=0, en <= 0.
- Overflow detection compares against {WIDTH{1'b1}}; there is no carry past WIDTH.
- Write priority in one cycle:
  - A bus write to TL overrides the count/reload.
  - A bus write to TCON overrides the hardware clear of en.
  - A pending set by overflow wins over a W1C clear in the same cycle.
- A write to TH takes effect on the next reload only; TL is not modified.
- IRQ and irq_id are combinational from the registered pending/irq_en. Clearing irq_en masks IRQ but leaves pending set.
- Read is combinational: rdata reflects register state before the clock edge of the current access. MemRead is informational only; rdata is decoded from addr regardless.
- Latency: overflow at edge k → pending=1 and IRQ=1 visible after edge k. W1C at edge k → IRQ=0 after edge k.

Test Plan:
1. Reset mid-count: ch0 TH=0xFFFF_FFF0, TL=0xFFFF_FFF0, TCON=0x7, run 5 cycles, pulse rst_n low → TL=0, TCON=0, IRQ=0 immediately, with no clock edge needed.
2. Auto-reload, PRESCALE=1: TH=TL=0xFFFF_FFFD, TCON=0x7 → TL reaches 0xFFFF_FFFF after 2 ticks. The 3rd tick reloads TL=0xFFFF_FFFD with IRQ=1, irq_id=0 and TCON read = 0xF. Overflows then repeat every 3 ticks.
3. One-shot: ch1 TH=0, TL=0xFFFF_FFFE, TCON=0x3 → after 2 ticks TL=0, IRQ=1, irq_id=1, and TCON reads 0xA (en cleared); TL then stays 0.
4. W1C vs. set collision: ch0 overflows in the same cycle as a write of 0x1 to STATUS → pending remains 1. A later write of 0x1 to STATUS → IRQ=0 on the next cycle.
5. Two channels pending, PRESCALE=4: both channels overflow → irq_id=0. Set ch0 irq_en=0 → IRQ stays 1, irq_id=1. Confirm TL advances once per 4 clk cycles.
6. Bus override: a write TL=0x10 coincides with a tick at TL=0x20 → TL=0x10 after the edge. An unmapped address read (BASE_ADDR+0x0C) → rdata=0.
